// File: rtl/reg_write_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : reg_seq_pkg
//  Description : Shared encodings for the Register write sequencer:
//                Register FunSel codes, high-level op codes and the
//                sequencer state enumeration.
//  Contents    : FS_* (3-bit FunSel), OP_* (2-bit op), state_e (FSM states)
//  Revision    : 1.0  initial release
// ============================================================================
package reg_seq_pkg;

  // Register function-select codes
  localparam logic [2:0] FS_DEC     = 3'b000;
  localparam logic [2:0] FS_INC     = 3'b001;
  localparam logic [2:0] FS_LOAD    = 3'b010;
  localparam logic [2:0] FS_CLR     = 3'b011;
  localparam logic [2:0] FS_WLO_CLR = 3'b100;  // high byte cleared, low byte written
  localparam logic [2:0] FS_WLO     = 3'b101;  // low byte written, high byte kept
  localparam logic [2:0] FS_WHI     = 3'b110;  // high byte written, low byte kept
  localparam logic [2:0] FS_WLO_SX  = 3'b111;  // low byte written, sign-extended

  // High-level request op codes
  localparam logic [1:0] OP_LOAD16 = 2'b00;
  localparam logic [1:0] OP_LOADSX = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_STEP   = 2'b11;

  // Byte lane width of the Register data input
  localparam int BYTE_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LO    = 4'd1,   // LOAD16 low-byte strobe
    ST_HI    = 4'd2,   // LOAD16 high-byte strobe
    ST_SX    = 4'd3,   // LOADSX strobe
    ST_CLR   = 4'd4,   // CLEAR strobe
    ST_ARM   = 4'd5,   // STEP: counter loaded and zero-tested, no strobe
    ST_STEP  = 4'd6,   // STEP: one inc/dec strobe per cycle
    ST_CHECK = 4'd7,   // readback compare
    ST_DONE  = 4'd8    // completion pulse
  } state_e;

endpackage
`default_nettype wire

// File: rtl/reg_write_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : reg_write_sequencer_if
//  Description : Register control bus between the write sequencer (master)
//                and one Register instance (slave).
//  Signals     : e       Register enable
//                funsel  Register function select (3 bits)
//                din     Register data input (only [7:0] carries data)
//                q       Register output, read back by the sequencer
//  Modports    : master (sequencer), slave (Register)
//  Revision    : 1.0  initial release
// ============================================================================
interface reg_write_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             e;
  logic [2:0]       funsel;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;

  modport master (output e, output funsel, output din, input  q);
  modport slave  (input  e, input  funsel, input  din, output q);
endinterface
`default_nettype wire

// File: rtl/reg_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_sequencer
//  Description : Turns one-cycle high-level requests (LOAD16, LOADSX, CLEAR,
//                STEP) into the E/FunSel/I strobe sequence a 16-bit Register
//                needs, then reads Q back and flags a mismatch.
//  Ports       : clk_i       clock, rising edge
//                rst_ni      synchronous active-low reset
//                start_i     request strobe, sampled only in IDLE
//                op_i        op code (OP_*)
//                data_i      LOAD16 word / LOADSX byte in [7:0]
//                count_i     STEP repetitions
//                dir_i       STEP direction (1 inc, 0 dec)
//                busy_o      op in progress
//                done_o      one-cycle completion pulse
//                mismatch_o  readback differed from expected (valid with done)
//                reg_bus     Register control bus (master side)
//  Notes       : WIDTH must be 16; the byte lane is fixed at 8 bits.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_write_sequencer
  import reg_seq_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CNT_W    = 8,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic [CNT_W-1:0]      count_i,
  input  logic                  dir_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mismatch_o,
  reg_write_sequencer_if.master reg_bus
);

  // Where the last strobe leads: readback compare, or straight to completion.
  localparam state_e ST_AFTER = CHECK_EN ? ST_CHECK : ST_DONE;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             dir_q,   dir_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] exp_q,   exp_d;
  logic             mis_q,   mis_d;

  // Registered outputs
  logic             e_q,    e_d;
  logic [2:0]       fs_q,   fs_d;
  logic [WIDTH-1:0] din_q,  din_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    mis_d   = mis_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          data_d = data_i;
          dir_d  = dir_i;
          cnt_d  = count_i;
          mis_d  = 1'b0;
          unique case (op_i)
            OP_LOAD16: begin
              state_d = ST_LO;
              exp_d   = data_i;
            end
            OP_LOADSX: begin
              state_d = ST_SX;
              exp_d   = {{(WIDTH-BYTE_W){data_i[BYTE_W-1]}}, data_i[BYTE_W-1:0]};
            end
            OP_CLEAR: begin
              state_d = ST_CLR;
              exp_d   = '0;
            end
            default: begin
              // STEP: Q captured now is the base; wrap is modulo 2^WIDTH.
              state_d = ST_ARM;
              exp_d   = dir_i ? (reg_bus.q + WIDTH'(count_i))
                              : (reg_bus.q - WIDTH'(count_i));
            end
          endcase
        end
      end
      ST_LO:                 state_d = ST_HI;
      ST_HI, ST_SX, ST_CLR:  state_d = ST_AFTER;
      ST_ARM:                state_d = (cnt_q == '0) ? ST_AFTER : ST_STEP;
      ST_STEP: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_AFTER;
        end
      end
      ST_CHECK: begin
        mis_d   = (reg_bus.q != exp_q);
        state_d = ST_DONE;
      end
      ST_DONE:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being
    // entered and the operand values that will be held in it.
    e_d    = 1'b0;
    fs_d   = FS_CLR;
    din_d  = '0;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);

    unique case (state_d)
      ST_LO: begin
        e_d   = 1'b1;
        fs_d  = FS_WLO_CLR;
        din_d = {{(WIDTH-BYTE_W){1'b0}}, data_d[BYTE_W-1:0]};
      end
      ST_HI: begin
        e_d   = 1'b1;
        fs_d  = FS_WHI;
        din_d = {{(WIDTH-BYTE_W){1'b0}}, data_d[2*BYTE_W-1:BYTE_W]};
      end
      ST_SX: begin
        e_d   = 1'b1;
        fs_d  = FS_WLO_SX;
        din_d = {{(WIDTH-BYTE_W){1'b0}}, data_d[BYTE_W-1:0]};
      end
      ST_CLR: begin
        e_d   = 1'b1;
        fs_d  = FS_CLR;
      end
      ST_STEP: begin
        e_d   = 1'b1;
        fs_d  = dir_d ? FS_INC : FS_DEC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      exp_q   <= '0;
      mis_q   <= 1'b0;
      e_q     <= 1'b0;
      fs_q    <= FS_CLR;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      mis_q   <= mis_d;
      e_q     <= e_d;
      fs_q    <= fs_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign reg_bus.e      = e_q;
  assign reg_bus.funsel = fs_q;
  assign reg_bus.din    = din_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign mismatch_o     = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_sequencer
//  Description : Self-checking bench for reg_write_sequencer driving a
//                behavioural 16-bit Register. Table of op vectors plus
//                hand-written reset / busy-ignore sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_write_sequencer;
  import reg_seq_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
  localparam int BUDGET = 40;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] data = '0;
  logic [CNT_W-1:0] count = '0;
  logic             dir = 1'b0;
  logic             busy, done, mismatch;

  logic [WIDTH-1:0] reg_q;
  logic             preset_en = 1'b0;
  logic [WIDTH-1:0] preset_val = '0;
  logic             stuck = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  reg_write_sequencer_if #(.WIDTH(WIDTH)) bus ();

  reg_write_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .CHECK_EN(1'b1)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .op_i       (op),
    .data_i     (data),
    .count_i    (count),
    .dir_i      (dir),
    .busy_o     (busy),
    .done_o     (done),
    .mismatch_o (mismatch),
    .reg_bus    (bus)
  );

  always #5 clk = ~clk;

  // Readback path; 'stuck' models a Q output shorted to zero.
  assign bus.q = stuck ? '0 : reg_q;

  // Behavioural Register (no reset; preset lets the bench choose a start value)
  always_ff @(posedge clk) begin
    if (preset_en) begin
      reg_q <= preset_val;
    end else if (bus.e) begin
      case (bus.funsel)
        FS_DEC:     reg_q <= reg_q - 16'd1;
        FS_INC:     reg_q <= reg_q + 16'd1;
        FS_LOAD:    reg_q <= bus.din;
        FS_CLR:     reg_q <= '0;
        FS_WLO_CLR: reg_q <= {8'h00, bus.din[7:0]};
        FS_WLO:     reg_q <= {reg_q[15:8], bus.din[7:0]};
        FS_WHI:     reg_q <= {bus.din[7:0], reg_q[7:0]};
        default:    reg_q <= {{8{bus.din[7]}}, bus.din[7:0]};
      endcase
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [7:0]  count;
    logic        dir;
    logic [15:0] q0;
    logic        stuck;
    int          n_strobe;
    logic [2:0]  fs_first;
    logic [7:0]  din_first;
    logic [2:0]  fs_last;
    logic [7:0]  din_last;
    int          lat;
    logic [15:0] q_exp;
    logic        mis_exp;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preset(input logic [15:0] v);
    preset_en  = 1'b1;
    preset_val = v;
    tick();
    preset_en  = 1'b0;
  endtask

  task automatic run_op(input int vi, input vec_t v);
    int         ns, lat;
    logic       seen, hi_bad, busy_bad, mis_at;
    logic [2:0] fs_f, fs_l;
    logic [7:0] d_f, d_l;
    logic [15:0] q_at;
    string      t;
    t = $sformatf("v%0d", vi);
    preset(v.q0);
    stuck = v.stuck;
    op = v.op; data = v.data; count = v.count; dir = v.dir; start = 1'b1;
    tick();
    // Scramble inputs after acceptance: the DUT must use latched values.
    start = 1'b0; op = 2'b00; data = 16'h5555; count = 8'hFF; dir = ~v.dir;
    ns = 0; lat = 0; seen = 1'b0; hi_bad = 1'b0; busy_bad = 1'b0;
    fs_f = '0; fs_l = '0; d_f = '0; d_l = '0; mis_at = 1'b0; q_at = '0;
    for (int c = 1; c <= BUDGET; c++) begin
      if (bus.e) begin
        if (ns == 0) begin fs_f = bus.funsel; d_f = bus.din[7:0]; end
        fs_l = bus.funsel; d_l = bus.din[7:0];
        if (bus.din[15:8] != 8'h00) hi_bad = 1'b1;
        ns++;
      end
      if (!busy) busy_bad = 1'b1;
      if (done) begin
        seen = 1'b1; lat = c; mis_at = mismatch; q_at = reg_q;
        break;
      end
      tick();
    end
    chk({t, "_done_seen"}, 32'(seen), 32'd1);
    chk({t, "_latency"}, 32'(lat), 32'(v.lat));
    chk({t, "_strobes"}, 32'(ns), 32'(v.n_strobe));
    if (ns > 0) begin
      chk({t, "_first_strobe"}, {21'd0, fs_f, d_f}, {21'd0, v.fs_first, v.din_first});
      chk({t, "_last_strobe"},  {21'd0, fs_l, d_l}, {21'd0, v.fs_last,  v.din_last});
    end
    chk({t, "_din_hi_zero"}, 32'(hi_bad), 32'd0);
    chk({t, "_busy_during"}, 32'(busy_bad), 32'd0);
    chk({t, "_reg_q"}, 32'(q_at), 32'(v.q_exp));
    chk({t, "_mismatch"}, 32'(mis_at), 32'(v.mis_exp));
    tick();
    chk({t, "_after_done_busy_done"}, {30'd0, busy, done}, 32'd0);
    stuck = 1'b0;
  endtask

  initial begin
    logic bad;
    int   ns;
    //           op         data      cnt    dir   q0        stk  ns fs_first   d_f    fs_last    d_l    lat q_exp     mis
    vecs[0] = '{OP_LOAD16, 16'hA55A, 8'd0, 1'b0, 16'h1234, 1'b0, 2, FS_WLO_CLR, 8'h5A, FS_WHI,    8'hA5, 4, 16'hA55A, 1'b0};
    vecs[1] = '{OP_LOADSX, 16'h0080, 8'd0, 1'b0, 16'h1234, 1'b0, 1, FS_WLO_SX,  8'h80, FS_WLO_SX, 8'h80, 3, 16'hFF80, 1'b0};
    vecs[2] = '{OP_LOADSX, 16'h007F, 8'd0, 1'b0, 16'hFF80, 1'b0, 1, FS_WLO_SX,  8'h7F, FS_WLO_SX, 8'h7F, 3, 16'h007F, 1'b0};
    vecs[3] = '{OP_CLEAR,  16'h0000, 8'd0, 1'b0, 16'hBEEF, 1'b0, 1, FS_CLR,     8'h00, FS_CLR,    8'h00, 3, 16'h0000, 1'b0};
    vecs[4] = '{OP_STEP,   16'h0000, 8'd3, 1'b1, 16'hFFFE, 1'b0, 3, FS_INC,     8'h00, FS_INC,    8'h00, 6, 16'h0001, 1'b0};
    vecs[5] = '{OP_STEP,   16'h0000, 8'd0, 1'b1, 16'h4321, 1'b0, 0, FS_INC,     8'h00, FS_INC,    8'h00, 3, 16'h4321, 1'b0};
    vecs[6] = '{OP_STEP,   16'h0000, 8'd2, 1'b0, 16'h0001, 1'b0, 2, FS_DEC,     8'h00, FS_DEC,    8'h00, 5, 16'hFFFF, 1'b0};
    vecs[7] = '{OP_LOAD16, 16'h00FF, 8'd0, 1'b0, 16'h1111, 1'b1, 2, FS_WLO_CLR, 8'hFF, FS_WHI,    8'h00, 4, 16'h00FF, 1'b1};
    vecs[8] = '{OP_LOADSX, 16'h00C3, 8'd0, 1'b0, 16'h0000, 1'b0, 1, FS_WLO_SX,  8'hC3, FS_WLO_SX, 8'hC3, 3, 16'hFFC3, 1'b0};

    // Reset state
    #1;
    preset(16'h1234);
    tick();
    chk("reset_e",      32'(bus.e), 32'd0);
    chk("reset_funsel", 32'(bus.funsel), 32'(FS_CLR));
    chk("reset_din",    32'(bus.din), 32'd0);
    chk("reset_flags",  {29'd0, busy, done, mismatch}, 32'd0);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.e || busy || done) bad = 1'b1;
    end
    chk("idle_quiet", 32'(bad), 32'd0);
    chk("idle_q_kept", 32'(reg_q), 32'h1234);

    // Table-driven ops
    foreach (vecs[i]) run_op(i, vecs[i]);

    // Start during Busy is ignored and not queued
    preset(16'h0000);
    op = OP_LOAD16; data = 16'hA55A; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op = OP_CLEAR; start = 1'b1;
    tick();
    start = 1'b0;
    bad = 1'b1;
    for (int c = 0; c < BUDGET; c++) begin
      if (done) begin bad = 1'b0; break; end
      tick();
    end
    chk("busy_ign_done_seen", 32'(bad), 32'd0);
    chk("busy_ign_q", 32'(reg_q), 32'hA55A);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.e || busy || done) bad = 1'b1;
    end
    chk("busy_ign_not_queued", 32'(bad), 32'd0);
    chk("busy_ign_q_kept", 32'(reg_q), 32'hA55A);

    // Reset mid-STEP after 4 strobes
    preset(16'h0100);
    op = OP_STEP; count = 8'd10; dir = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    ns = 0;
    for (int c = 0; c < BUDGET; c++) begin
      if (bus.e) ns++;
      if (ns == 4) break;
      tick();
    end
    chk("midstep_strobes_seen", 32'(ns), 32'd4);
    rst_n = 1'b0;
    start = 1'b1;  // reset must win over a simultaneous request
    tick();
    chk("midstep_reset_e_busy", {30'd0, bus.e, busy}, 32'd0);
    tick();
    chk("reset_wins_over_start", {30'd0, busy, bus.e}, 32'd0);
    chk("midstep_q", 32'(reg_q), 32'h0104);
    rst_n = 1'b1;
    start = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.e || busy || done) bad = 1'b1;
    end
    chk("midstep_abandoned", 32'(bad), 32'd0);
    chk("midstep_q_kept", 32'(reg_q), 32'h0104);
    run_op(9, vecs[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
